// File: rtl/best_move_select.sv
// Scans the generated move list one post-move board at a time, scores the material
// rank by rank, and keeps the best move for the side to move at the root.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 256
`endif

module best_move_select #(
  parameter int PIECE_WIDTH        = `PIECE_BITS,
  parameter int SIDE_WIDTH         = PIECE_WIDTH*8,
  parameter int BOARD_WIDTH        = PIECE_WIDTH*64,
  parameter int MAX_POSITIONS      = `MAX_POSITIONS,
  parameter int MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
  input  logic [BOARD_WIDTH-1:0]        board_in,
  input  logic                          white_to_move,
  output logic [MAX_POSITIONS_LOG2-1:0] move_index,
  output logic                          clear_moves,
  output logic [MAX_POSITIONS_LOG2-1:0] best_index,
  output logic signed [15:0]            best_score,
  output logic                          no_moves,
  output logic                          select_done
);

  typedef enum logic [2:0] {IDLE, WAIT1, WAIT2, SCORE, COMPARE, CLEAR, DONE} state_t;

  localparam logic [MAX_POSITIONS_LOG2:0] MAX_INDEX = MAX_POSITIONS[MAX_POSITIONS_LOG2:0];

  state_t                          state, state_next;
  logic                            ready_q;
  logic                            armed;
  logic                            start;
  logic [MAX_POSITIONS_LOG2-1:0]   count_q;
  logic                            white_q;
  logic [2:0]                      rank;
  logic signed [15:0]              acc;
  logic [SIDE_WIDTH-1:0]           rank_bits;
  logic signed [15:0]              rank_sum;
  logic [MAX_POSITIONS_LOG2:0]     next_index;
  logic                            last_move;
  logic                            better;

  // Piece code: low three bits select the type, the top bit marks a black piece.
  function automatic logic signed [15:0] square_value(input logic [PIECE_WIDTH-1:0] sq);
    logic signed [15:0] mag;
    case (sq[2:0])
      3'd1:       mag = 16'sd100;
      3'd2, 3'd3: mag = 16'sd300;
      3'd4:       mag = 16'sd500;
      3'd5:       mag = 16'sd900;
      default:    mag = 16'sd0;
    endcase
    return sq[PIECE_WIDTH-1] ? -mag : mag;
  endfunction

  always_comb begin
    rank_bits = board_in[rank*SIDE_WIDTH +: SIDE_WIDTH];
    rank_sum  = '0;
    for (int f = 0; f < 8; f++) begin
      rank_sum = rank_sum + square_value(rank_bits[f*PIECE_WIDTH +: PIECE_WIDTH]);
    end
  end

  // A start needs a genuine low-to-high transition seen after reset, hence the armed flag.
  assign start      = (state == IDLE) && moves_ready && !ready_q && armed;
  assign next_index = {1'b0, move_index} + 1'b1;
  assign last_move  = (next_index >= {1'b0, count_q}) || (next_index >= MAX_INDEX);
  assign better     = (move_index == '0) ||
                      (white_q ? (acc > best_score) : (acc < best_score));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (move_count == '0) ? CLEAR : WAIT1;
      WAIT1:   state_next = WAIT2;
      WAIT2:   state_next = SCORE;
      SCORE:   if (rank == 3'd7) state_next = COMPARE;
      COMPARE: state_next = last_move ? CLEAR : WAIT1;
      CLEAR:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q     <= 1'b0;
      armed       <= 1'b0;
      count_q     <= '0;
      white_q     <= 1'b0;
      rank        <= '0;
      acc         <= '0;
      move_index  <= '0;
      best_index  <= '0;
      best_score  <= '0;
      no_moves    <= 1'b0;
      clear_moves <= 1'b0;
      select_done <= 1'b0;
    end else begin
      ready_q     <= moves_ready;
      if (!moves_ready) armed <= 1'b1;
      clear_moves <= (state == CLEAR);
      select_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            count_q    <= move_count;
            white_q    <= white_to_move;
            move_index <= '0;
            best_index <= '0;
            best_score <= '0;
            no_moves   <= (move_count == '0);
            rank       <= '0;
            acc        <= '0;
          end
        end
        SCORE: begin
          acc  <= acc + rank_sum;
          rank <= rank + 3'd1;
        end
        COMPARE: begin
          if (better) begin
            best_index <= move_index;
            best_score <= acc;
          end
          acc <= '0;
          if (!last_move) move_index <= move_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_best_move_select.sv
// Self-checking bench for best_move_select: a small move RAM with 2-cycle read latency
// feeds boards, and a material model predicts the chosen move and pulse timing.
`timescale 1ns/1ps
module tb_best_move_select;
  localparam int IW = 8;
  localparam int BW = 256;
  localparam logic [3:0] WP = 4'd1, WN = 4'd2, WB = 4'd3, WR = 4'd4, WQ = 4'd5, WK = 4'd6;
  localparam logic [3:0] BP = 4'd9, BR = 4'd12, BQ = 4'd13, BK = 4'd14, BN = 4'd10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic moves_ready = 1'b0;
  logic white_to_move = 1'b0;
  logic [IW-1:0] move_count = '0;
  logic [BW-1:0] board_in;
  logic [IW-1:0] move_index, best_index;
  logic signed [15:0] best_score;
  logic clear_moves, no_moves, select_done;

  logic [BW-1:0] ram [0:31];
  logic [IW-1:0] ram_addr_q;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int start_edge = 0;
  int done_edge = -1;
  int exp_n = 0;
  int exp_best_idx = 0;
  int exp_best_score = 0;
  bit exp_no_moves = 1'b0;
  bit scan_active = 1'b0;
  bit results_valid = 1'b0;
  int value_of [8] = '{0, 100, 300, 300, 500, 900, 0, 0};

  always #5 clk = ~clk;

  best_move_select dut (
    .clk(clk), .reset(reset), .moves_ready(moves_ready), .move_count(move_count),
    .board_in(board_in), .white_to_move(white_to_move), .move_index(move_index),
    .clear_moves(clear_moves), .best_index(best_index), .best_score(best_score),
    .no_moves(no_moves), .select_done(select_done)
  );

  // Move RAM: address registered, then data registered.
  always @(posedge clk) begin
    ram_addr_q <= move_index;
    board_in   <= ram[ram_addr_q[4:0]];
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at edge %0d", name, actual, expected, edge_cnt);
    end
  endtask

  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int sq, input logic [3:0] pc);
    b[sq*4 +: 4] = pc;
    return b;
  endfunction

  function automatic int material(input logic [BW-1:0] b);
    int total = 0;
    logic [3:0] pc;
    for (int s = 0; s < 64; s++) begin
      pc = b[s*4 +: 4];
      total += pc[3] ? -value_of[pc[2:0]] : value_of[pc[2:0]];
    end
    return total;
  endfunction

  task automatic model_scan(input int n, input bit white);
    int s;
    exp_n = n;
    exp_no_moves = (n == 0);
    exp_best_idx = 0;
    exp_best_score = 0;
    for (int i = 0; i < n; i++) begin
      s = material(ram[i]);
      if (i == 0 || (white && s > exp_best_score) || (!white && s < exp_best_score)) begin
        exp_best_idx = i;
        exp_best_score = s;
      end
    end
  endtask

  task automatic apply_stimulus(input int n, input bit white);
    @(posedge clk); #2;
    moves_ready = 1'b0;
    move_count = n[IW-1:0];
    white_to_move = white;
    @(posedge clk); #2;
    model_scan(n, white);
    start_edge = edge_cnt + 1;
    done_edge = -1;
    results_valid = 1'b0;
    scan_active = 1'b1;
    moves_ready = 1'b1;
  endtask

  task automatic wait_done(input int n);
    int limit;
    limit = start_edge + 11*n + 6;
    while (edge_cnt < limit) @(posedge clk);
    #2;
    check_output("done_latency", done_edge - start_edge, 11*n + 2);
  endtask

  // Every negedge: outputs are zero in reset, pulses land exactly when predicted,
  // results match the model from select_done until the next start.
  always @(negedge clk) begin
    if (!reset) begin
      check_output("reset_outputs",
        longint'({move_index, clear_moves, best_index, best_score, no_moves, select_done}), 0);
    end else begin
      check_output("clear_moves", clear_moves,
        scan_active && (edge_cnt == start_edge + 11*exp_n + 1));
      check_output("select_done", select_done,
        scan_active && (edge_cnt == start_edge + 11*exp_n + 2));
      if (select_done) done_edge = edge_cnt;
      if (scan_active && edge_cnt == start_edge + 11*exp_n + 2) begin
        scan_active = 1'b0;
        results_valid = 1'b1;
      end
      if (results_valid) begin
        check_output("best_index", best_index, exp_best_idx);
        check_output("best_score", longint'(best_score), exp_best_score);
        check_output("no_moves", no_moves, exp_no_moves);
      end
    end
  end

  logic [BW-1:0] base_a, base_b, base_c, base_d;

  task automatic load_mixed();
    ram[0] = put(base_d, 9, WP);
    ram[1] = put(base_d, 2, WB);
    ram[2] = put(base_d, 6, WN);
    ram[3] = put(put(base_d, 8, 4'd0), 1, 4'd0);
  endtask

  initial begin
    base_a = '0;
    base_a = put(put(put(base_a, 4, WK), 60, BK), 0, WR);
    base_a = put(put(put(base_a, 7, WR), 56, BR), 63, BR);
    base_b = put(put(base_a, 3, WQ), 59, BQ);
    base_c = put(put('0, 4, WK), 60, BK);
    base_d = put(put(put(put(base_c, 8, WP), 48, BP), 1, WN), 57, BN);
    for (int i = 0; i < 32; i++) ram[i] = '0;

    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Rooks and kings only: every move scores 0, first index wins.
    for (int i = 0; i < 26; i++) ram[i] = base_a;
    apply_stimulus(26, 1'b1);
    check_output("model_rooks_idx", exp_best_idx, 0);
    wait_done(26);
    check_output("rooks_latency", done_edge - start_edge, 288);
    check_output("rooks_score", longint'(best_score), 0);

    // moves_ready left high: no retrigger.
    move_count = '0;
    repeat (6) @(posedge clk);

    // Queen capture on move 3; inputs change mid-scan and must be ignored.
    for (int i = 0; i < 5; i++) ram[i] = base_b;
    ram[3] = put(put(base_b, 3, 4'd0), 59, WQ);
    apply_stimulus(5, 1'b1);
    check_output("model_capture_score", exp_best_score, 900);
    repeat (4) @(posedge clk);
    #2 move_count = 8'd1; white_to_move = 1'b0;
    wait_done(5);
    check_output("capture_idx", best_index, 3);
    check_output("capture_score", longint'(best_score), 900);

    // Black to move with a tie at the best score.
    ram[0] = put(base_c, 56, BR);
    ram[1] = put(put(base_c, 56, BR), 59, BQ);
    ram[2] = put(put(base_c, 63, BR), 58, BQ);
    apply_stimulus(3, 1'b0);
    check_output("model_black_idx", exp_best_idx, 1);
    wait_done(3);
    check_output("black_idx", best_index, 1);
    check_output("black_score", longint'(best_score), -1400);

    // Empty move list.
    apply_stimulus(0, 1'b1);
    wait_done(0);
    check_output("empty_no_moves", no_moves, 1);
    check_output("empty_idx", best_index, 0);

    // Mixed pieces across ranks, white to move, tie between moves 1 and 2.
    load_mixed();
    apply_stimulus(4, 1'b1);
    check_output("model_mixed_score", exp_best_score, 300);
    wait_done(4);
    check_output("mixed_idx", best_index, 1);

    // Black to move with only positive scores: first move must seed the best.
    ram[0] = put(put(base_d, 2, WB), 50, BP);
    ram[1] = put(base_d, 10, WP);
    apply_stimulus(2, 1'b0);
    check_output("model_seed_score", exp_best_score, 100);
    wait_done(2);
    check_output("seed_idx", best_index, 1);

    // Reset during SCORE of move 2, then a clean rescan.
    load_mixed();
    apply_stimulus(4, 1'b1);
    while (edge_cnt < start_edge + 26) @(posedge clk);
    #3 reset = 1'b0;
    scan_active = 1'b0;
    results_valid = 1'b0;
    #1 check_output("abort_outputs",
      longint'({move_index, clear_moves, best_index, best_score, no_moves, select_done}), 0);
    repeat (3) @(posedge clk);
    #2 move_count = '0;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    apply_stimulus(4, 1'b1);
    wait_done(4);
    check_output("rescan_idx", best_index, 1);
    check_output("rescan_score", longint'(best_score), 300);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/best_move_select.md
BEST_MOVE_SELECT -- requirements
Module: best_move_select

Interface
REQ-001 SHALL have parameter PIECE_WIDTH, default `PIECE_BITS, bits per square.
REQ-002 SHALL have parameter SIDE_WIDTH, default PIECE_WIDTH*8, bits per rank.
REQ-003 SHALL have parameter BOARD_WIDTH, default PIECE_WIDTH*64, bits per board.
REQ-004 SHALL have parameter MAX_POSITIONS, default `MAX_POSITIONS, move RAM depth.
REQ-005 SHALL have parameter MAX_POSITIONS_LOG2, default $clog2(`MAX_POSITIONS), index width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port moves_ready, input, 1, move list valid, from all_moves.
REQ-009 SHALL have port move_count, input, MAX_POSITIONS_LOG2, number of generated moves.
REQ-010 SHALL have port board_in, input, BOARD_WIDTH, post-move board read from the move RAM (all_moves board_out).
REQ-011 SHALL have port white_to_move, input, 1, side to move at the root position.
REQ-012 SHALL have port move_index, output, MAX_POSITIONS_LOG2, move RAM read address.
REQ-013 SHALL have port clear_moves, output, 1, one-cycle pulse that releases all_moves for the next position.
REQ-014 SHALL have port best_index, output, MAX_POSITIONS_LOG2, index of selected move.
REQ-015 SHALL have port best_score, output, 16, signed material score of the selected move.
REQ-016 SHALL have port no_moves, output, 1, set when move_count was 0.
REQ-017 SHALL have port select_done, output, 1, one-cycle pulse when the result is valid.

Function
REQ-018 SHALL start a scan only on a rising edge of moves_ready sampled in IDLE; moves_ready held high after a scan SHALL NOT retrigger it.
REQ-019 SHALL capture move_count and white_to_move at start; input changes mid-scan SHALL be ignored.
REQ-020 SHALL implement states IDLE, WAIT1, WAIT2, SCORE, COMPARE, CLEAR, DONE.
REQ-021 On start with count>0, SHALL set move_index=0 and go to WAIT1; with count=0, SHALL go to CLEAR and set no_moves=1.
REQ-022 WAIT1 and WAIT2 SHALL be one cycle each, covering the 2-cycle move RAM read latency; board_in SHALL be sampled only in SCORE.
REQ-023 SCORE SHALL last 8 cycles, accumulating one rank (8 squares) per cycle into a signed 16-bit sum.
REQ-024 Square values SHALL be: pawn 100, knight 300, bishop 300, rook 500, queen 900, king 0, empty 0; white positive, black negative.
REQ-025 COMPARE SHALL replace the best result if it is the first move, or if score > best (white to move), or if score < best (black to move).
REQ-026 Ties SHALL keep the lower index.
REQ-027 COMPARE SHALL then increment move_index and go to WAIT1 if index+1 < count, else go to CLEAR.
REQ-028 CLEAR SHALL assert clear_moves for exactly one cycle, then go to DONE.
REQ-029 DONE SHALL assert select_done for exactly one cycle, then go to IDLE.
REQ-030 best_index, best_score and no_moves SHALL hold from select_done until the next start, and SHALL be cleared to 0 at each start.
REQ-031 Per-move cost SHALL be 11 cycles; select_done SHALL rise 11*N+2 edges after the edge sampling the start, where N=move_count.
REQ-032 The score accumulator SHALL not overflow for any legal material (max magnitude 10300).

Reset
REQ-033 While reset=0, SHALL force state IDLE, all outputs 0, and the moves_ready edge detector to 0, asynchronously.
REQ-034 Reset asserted mid-scan SHALL abort it without a clear_moves or select_done pulse.
REQ-035 After reset deasserts with moves_ready already high, SHALL NOT start until moves_ready falls and rises again.

Verification
REQ-036 Kings plus four rooks, white to move, 26 moves, all scores 0: best_index=0, best_score=0, select_done 288 edges after start.
REQ-037 White to move, move 3 captures a black queen (+900 vs 0 for the others): best_index=3, best_score=900.
REQ-038 Black to move, moves score {-500,-1400,-1400}: best_index=1, best_score=-1400 (tie keeps index 1).
REQ-039 move_count=0: no_moves=1, clear_moves pulse, then select_done 2 edges after start, best_index=0.
REQ-040 Reset pulled low during SCORE of move 2: outputs 0 immediately, no pulses; rescan after a fresh moves_ready edge matches an uninterrupted run.
